// File: rtl/reg_campo_bcd.sv
// Editable BCD time/date field: debounced key stepping with hold-to-repeat,
// validated loads from the RTC read path, and wrap/edit/error flags.
module reg_campo_bcd #(
  parameter int DIGITS        = 2,
  parameter int MIN_VAL       = 1,
  parameter int MAX_VAL       = 12,
  parameter int RESET_VAL     = 1,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                UP,
  input  logic                DOWN,
  input  logic                Modificando,
  input  logic                Actualizar,
  input  logic [4*DIGITS-1:0] DATA_in,
  output logic [4*DIGITS-1:0] DATA_out,
  output logic                Acarreo,
  output logic                Prestamo,
  output logic                Cambio,
  output logic                ErrorCarga
);
  localparam int W       = 4 * DIGITS;
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  function automatic logic [W-1:0] to_bcd(input int n);
    int           r;
    logic [W-1:0] b;
    r = n;
    b = '0;
    for (int d = 0; d < DIGITS; d++) begin
      b[4*d +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (v[4*d +: 4] >= 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (b) begin
        if (v[4*d +: 4] == 4'd0) begin
          r[4*d +: 4] = 4'd9;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  localparam logic [W-1:0]     MIN_BCD   = to_bcd(MIN_VAL);
  localparam logic [W-1:0]     MAX_BCD   = to_bcd(MAX_VAL);
  localparam logic [W-1:0]     RST_BCD   = to_bcd(RESET_VAL);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ESPERA, REPETIR} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             dir, dir_nx;
  logic             up_prev, down_prev, lock;
  logic             key_up, key_dn, key_same, edge_key, step, load_ok;

  assign key_up   = Modificando & UP & ~DOWN;
  assign key_dn   = Modificando & DOWN & ~UP;
  assign key_same = dir ? key_dn : key_up;
  // lock keeps a key held through reset from stepping until it is released
  assign edge_key = ~lock & ((key_up & ~up_prev) | (key_dn & ~down_prev));
  // for valid BCD, numeric order matches unsigned order of the packed digits
  assign load_ok  = bcd_valid(DATA_in) && (DATA_in >= MIN_BCD) && (DATA_in <= MAX_BCD);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dir_nx   = dir;
    step     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (edge_key) begin
          step     = 1'b1;
          state_nx = ESPERA;
          dir_nx   = key_dn;
        end
      end
      ESPERA: begin
        if (!key_same) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (HOLD_CYCLES != 0) begin
          if (cnt == HOLD_LAST) begin
            step     = 1'b1;
            state_nx = REPETIR;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      REPETIR: begin
        if (!key_same) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == REP_LAST) begin
          step   = 1'b1;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      dir        <= 1'b0;
      up_prev    <= 1'b0;
      down_prev  <= 1'b0;
      lock       <= 1'b1;
      DATA_out   <= RST_BCD;
      Acarreo    <= 1'b0;
      Prestamo   <= 1'b0;
      Cambio     <= 1'b0;
      ErrorCarga <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      dir        <= dir_nx;
      up_prev    <= UP;
      down_prev  <= DOWN;
      Acarreo    <= 1'b0;
      Prestamo   <= 1'b0;
      ErrorCarga <= 1'b0;
      if (!UP && !DOWN) lock <= 1'b0;
      if (step) begin
        Cambio <= 1'b1;
        if (dir_nx) begin
          if (DATA_out == MIN_BCD) begin
            DATA_out <= MAX_BCD;
            Prestamo <= 1'b1;
          end else begin
            DATA_out <= bcd_dec(DATA_out);
          end
        end else begin
          if (DATA_out == MAX_BCD) begin
            DATA_out <= MIN_BCD;
            Acarreo  <= 1'b1;
          end else begin
            DATA_out <= bcd_inc(DATA_out);
          end
        end
      end else if (!Modificando && Actualizar) begin
        if (load_ok) begin
          DATA_out <= DATA_in;
          Cambio   <= 1'b0;
        end else begin
          ErrorCarga <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_campo_bcd.sv
// Directed bench for reg_campo_bcd with a 2-digit 1..12 field and short hold/repeat times.
module tb_reg_campo_bcd;
  logic       clk = 1'b0;
  logic       rst, up, down, modif, actual;
  logic [7:0] din, dout;
  logic       acarreo, prestamo, cambio, err;
  int         checks = 0;
  int         failures = 0;

  logic [7:0] cnt_exp  [9]  = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10};
  logic [7:0] hold_exp [10] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04, 8'h05, 8'h05};
  logic [7:0] ld_in    [6]  = '{8'h07, 8'h13, 8'h1A, 8'h00, 8'h12, 8'h01};
  logic [7:0] ld_out   [6]  = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h12, 8'h01};
  logic       ld_err   [6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  reg_campo_bcd #(
    .DIGITS(2), .MIN_VAL(1), .MAX_VAL(12), .RESET_VAL(1),
    .HOLD_CYCLES(4), .REPEAT_CYCLES(2)
  ) dut (
    .CLK(clk), .RST(rst), .UP(up), .DOWN(down),
    .Modificando(modif), .Actualizar(actual), .DATA_in(din),
    .DATA_out(dout), .Acarreo(acarreo), .Prestamo(prestamo),
    .Cambio(cambio), .ErrorCarga(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; up = 1'b0; down = 1'b0; modif = 1'b0; actual = 1'b0; din = 8'h00;
    tick();
    tick();
    checks++;
    if (dout !== 8'h01 || acarreo !== 1'b0 || prestamo !== 1'b0 || cambio !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%h/%b%b%b%b exp=01/0000", dout, acarreo, prestamo, cambio, err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (dout !== 8'h01) begin
      failures++;
      $display("FAIL reset_release got=%h exp=01", dout);
    end
  endtask

  task automatic test_count();
    modif = 1'b1;
    for (int i = 0; i < 9; i++) begin
      up = 1'b1;
      tick();
      checks++;
      if (dout !== cnt_exp[i] || acarreo !== 1'b0) begin
        failures++;
        $display("FAIL count_step%0d got=%h acarreo=%b exp=%h acarreo=0", i, dout, acarreo, cnt_exp[i]);
      end
      up = 1'b0;
      tick();
    end
    checks++;
    if (cambio !== 1'b1) begin
      failures++;
      $display("FAIL count_cambio got=%b exp=1", cambio);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 2; i++) begin
      up = 1'b1; tick(); up = 1'b0; tick();
    end
    checks++;
    if (dout !== 8'h12) begin
      failures++;
      $display("FAIL wrap_setup got=%h exp=12", dout);
    end
    up = 1'b1;
    tick();
    checks++;
    if (dout !== 8'h01 || acarreo !== 1'b1) begin
      failures++;
      $display("FAIL wrap_up got=%h acarreo=%b exp=01 acarreo=1", dout, acarreo);
    end
    up = 1'b0;
    tick();
    checks++;
    if (acarreo !== 1'b0) begin
      failures++;
      $display("FAIL wrap_up_pulse got=%b exp=0", acarreo);
    end
    down = 1'b1;
    tick();
    checks++;
    if (dout !== 8'h12 || prestamo !== 1'b1) begin
      failures++;
      $display("FAIL wrap_down got=%h prestamo=%b exp=12 prestamo=1", dout, prestamo);
    end
    down = 1'b0;
    tick();
    checks++;
    if (prestamo !== 1'b0 || dout !== 8'h12) begin
      failures++;
      $display("FAIL wrap_down_pulse got=%h prestamo=%b exp=12 prestamo=0", dout, prestamo);
    end
    up = 1'b1; tick(); up = 1'b0; tick();
    checks++;
    if (dout !== 8'h01) begin
      failures++;
      $display("FAIL wrap_back got=%h exp=01", dout);
    end
  endtask

  task automatic test_hold();
    up = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (dout !== hold_exp[c]) begin
        failures++;
        $display("FAIL hold_cycle%0d got=%h exp=%h", c, dout, hold_exp[c]);
      end
    end
    checks++;
    if (cambio !== 1'b1) begin
      failures++;
      $display("FAIL hold_cambio got=%b exp=1", cambio);
    end
    up = 1'b0;
    tick();
    checks++;
    if (dout !== 8'h05) begin
      failures++;
      $display("FAIL hold_release got=%h exp=05", dout);
    end
  endtask

  task automatic test_load();
    modif = 1'b0; actual = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = ld_in[i];
      tick();
      checks++;
      if (dout !== ld_out[i] || err !== ld_err[i]) begin
        failures++;
        $display("FAIL load_%h got=%h err=%b exp=%h err=%b", ld_in[i], dout, err, ld_out[i], ld_err[i]);
      end
      if (i == 0) begin
        checks++;
        if (cambio !== 1'b0) begin
          failures++;
          $display("FAIL load_cambio_clear got=%b exp=0", cambio);
        end
      end
    end
    actual = 1'b0;
    tick();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL load_err_pulse got=%b exp=0", err);
    end
    modif = 1'b1; up = 1'b1; tick(); up = 1'b0; tick();
    modif = 1'b0; actual = 1'b1; din = 8'h13;
    tick();
    checks++;
    if (dout !== 8'h02 || err !== 1'b1 || cambio !== 1'b1) begin
      failures++;
      $display("FAIL load_reject_keeps got=%h err=%b cambio=%b exp=02 err=1 cambio=1", dout, err, cambio);
    end
    actual = 1'b0; up = 1'b1;
    tick();
    checks++;
    if (dout !== 8'h02) begin
      failures++;
      $display("FAIL step_without_edit got=%h exp=02", dout);
    end
    up = 1'b0;
    tick();
  endtask

  task automatic test_conflict();
    modif = 1'b1; up = 1'b1; down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dout !== 8'h02 || acarreo !== 1'b0 || prestamo !== 1'b0) begin
        failures++;
        $display("FAIL both_keys%0d got=%h a=%b p=%b exp=02 a=0 p=0", i, dout, acarreo, prestamo);
      end
    end
    up = 1'b0; down = 1'b0;
    tick();
    actual = 1'b1; din = 8'h07;
    tick();
    checks++;
    if (dout !== 8'h02 || err !== 1'b0) begin
      failures++;
      $display("FAIL load_while_edit got=%h err=%b exp=02 err=0", dout, err);
    end
    din = 8'h1A;
    tick();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL bad_load_while_edit got=%b exp=0", err);
    end
    actual = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    up = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    checks++;
    if (dout !== 8'h05) begin
      failures++;
      $display("FAIL repeat_before_reset got=%h exp=05", dout);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (dout !== 8'h01 || cambio !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_repeat got=%h cambio=%b exp=01 cambio=0", dout, cambio);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (dout !== 8'h01) begin
        failures++;
        $display("FAIL held_after_reset%0d got=%h exp=01", c, dout);
      end
    end
    up = 1'b0;
    tick();
    up = 1'b1;
    tick();
    checks++;
    if (dout !== 8'h02) begin
      failures++;
      $display("FAIL repress_after_reset got=%h exp=02", dout);
    end
    up = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_hold();
    test_load();
    test_conflict();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_campo_bcd.md
REG_CAMPO_BCD -- requirements
Module: reg_campo_bcd

Interface
- REQ-001: Parameter DIGITS, 2: number of BCD digits; data width W = 4*DIGITS; legal 1..4.
- REQ-002: Parameter MIN_VAL, 1: lowest legal field value, binary integer.
- REQ-003: Parameter MAX_VAL, 12: highest legal field value, binary integer; MIN_VAL < MAX_VAL < 10^DIGITS.
- REQ-004: Parameter RESET_VAL, 1: value after reset; MIN_VAL..MAX_VAL.
- REQ-005: Parameter HOLD_CYCLES, 25000000: cycles a key must be held before auto-repeat starts; 0 disables auto-repeat.
- REQ-006: Parameter REPEAT_CYCLES, 5000000: cycles between auto-repeat steps; >= 1.
- REQ-007: CLK  in  1  single system clock; all logic on its rising edge.
- REQ-008: RST  in  1  synchronous, active-high reset.
- REQ-009: UP  in  1  increment key, level, already debounced.
- REQ-010: DOWN  in  1  decrement key, level, already debounced.
- REQ-011: Modificando  in  1  1 = user editing; steps enabled, loads blocked.
- REQ-012: Actualizar  in  1  1 = load DATA_in when not editing.
- REQ-013: DATA_in  in  W  BCD value from RTC read path.
- REQ-014: DATA_out  out  W  registered BCD field value.
- REQ-015: Acarreo  out  1  one-cycle pulse on increment wrap MAX_VAL -> MIN_VAL.
- REQ-016: Prestamo  out  1  one-cycle pulse on decrement wrap MIN_VAL -> MAX_VAL.
- REQ-017: Cambio  out  1  sticky: field edited since last successful load.
- REQ-018: ErrorCarga  out  1  one-cycle pulse: load rejected.

Function
- REQ-019: Key FSM states IDLE, ESPERA, REPETIR; previous UP/DOWN held in registers for edge detection.
- REQ-020: Key request valid only when Modificando=1 and exactly one of UP/DOWN is 1; UP=DOWN=1 or both 0 -> IDLE, hold counter cleared, no step.
- REQ-021: IDLE: on the edge where a valid key is sampled 1 and was 0 on the previous edge, DATA_out steps once on that same edge; FSM -> ESPERA, counter cleared.
- REQ-022: ESPERA: counter increments each cycle key stays held; at HOLD_CYCLES-1 one step, -> REPETIR, counter cleared; HOLD_CYCLES=0 -> remain in ESPERA, no further steps.
- REQ-023: REPETIR: one step every REPEAT_CYCLES cycles while key held.
- REQ-024: Release, key swap, or Modificando=0 in any state -> IDLE next edge, no step that edge.
- REQ-025: Increment: per-digit BCD add with decimal carry; value == MAX_VAL -> MIN_VAL with Acarreo=1 for that cycle.
- REQ-026: Decrement: per-digit BCD subtract with decimal borrow; value == MIN_VAL -> MAX_VAL with Prestamo=1 for that cycle.
- REQ-027: Any step sets Cambio=1.
- REQ-028: Load: Modificando=0 and Actualizar=1 -> if every DATA_in digit <= 9 and MIN_VAL <= value <= MAX_VAL, DATA_out = DATA_in on that edge, Cambio=0; else DATA_out unchanged, ErrorCarga=1 for one cycle, Cambio unchanged.
- REQ-029: Actualizar ignored while Modificando=1; steps ignored while Modificando=0.
- REQ-030: DATA_out never holds an out-of-range or non-BCD value.

Reset
- REQ-031: RST=1 at a rising edge: DATA_out=BCD(RESET_VAL), Acarreo=Prestamo=ErrorCarga=0, Cambio=0, FSM=IDLE, counters and edge registers 0; overrides every other input incl. mid-repeat.
- REQ-032: After RST release, a key already held does not step until released and pressed again.

Verification (DIGITS=2, MIN=1, MAX=12, RESET=1, HOLD=4, REPEAT=2)
- REQ-033: Reset, Modificando=1, 9 UP pulses -> DATA_out 0x02..0x09, then 0x10 (decimal carry), no Acarreo.
- REQ-034: DATA_out=0x12, one UP pulse -> 0x01, Acarreo=1 one cycle; from 0x01 one DOWN pulse -> 0x12, Prestamo=1 one cycle.
- REQ-035: From 0x01 hold UP 10 cycles -> steps at cycles 0, 4, 6, 8: DATA_out 0x02, 0x03, 0x04, 0x05; Cambio=1.
- REQ-036: Modificando=0, Actualizar=1: DATA_in=0x07 -> 0x07, Cambio=0; DATA_in=0x13 or 0x1A or 0x00 -> unchanged, ErrorCarga pulse.
- REQ-037: UP and DOWN both 1; Actualizar=1 with Modificando=1 -> DATA_out unchanged, no pulses.
- REQ-038: Assert RST during REPETIR -> DATA_out=0x01 next edge; no step until UP released and re-pressed.
